// File: rtl/cla_pkg.sv
// Shared constants and stage record for the pipelined carry-lookahead adder.
// Optional saturation is enabled with the CLA_PIPE_SAT_EN macro.
package cla_pkg;

    localparam int CLA_WIDTH_DEF = 32;
    localparam int CLA_SEG_DEF   = 8;
    localparam int CLA_SEG_MIN   = 4;
    localparam int CLA_SEG_MAX   = 16;
    localparam int CLA_WIDTH_MAX = 64;

    // One pipeline slot: resolved low bits in psum, operands travel whole
    typedef struct packed {
        logic                     valid;
        logic [CLA_WIDTH_MAX-1:0] psum;
        logic                     carry;
        logic                     ovf;
        logic [CLA_WIDTH_MAX-1:0] a;
        logic [CLA_WIDTH_MAX-1:0] b;
        logic                     sub;
        logic                     sat;
    } cla_stage_t;

    function automatic bit cla_cfg_ok(input int w, input int s);
        return (s >= CLA_SEG_MIN) && (s <= CLA_SEG_MAX) &&
               (w > 0) && (w <= CLA_WIDTH_MAX) && ((w % s) == 0);
    endfunction

endpackage

// File: rtl/cla_seg.sv
// Combinational SEG-bit carry-lookahead slice.
// Exposes the carry into the top bit so the caller can form overflow.
module cla_seg #(
    parameter int SEG = 8
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           ci,
    output logic [SEG-1:0] s,
    output logic           co,
    output logic           c_msb
);

    logic [SEG-1:0] p;
    logic [SEG-1:0] g;
    logic [SEG:0]   c;

    assign p = a ^ b;
    assign g = a & b;

    // Each carry is a flat sum of generate terms, no ripple chain
    always_comb begin
        logic t;
        logic gp;
        c    = '0;
        c[0] = ci;
        for (int i = 0; i < SEG; i++) begin
            t = ci;
            for (int j = 0; j <= i; j++) begin
                t = t & p[j];
            end
            for (int j = 0; j <= i; j++) begin
                gp = g[j];
                for (int m = j + 1; m <= i; m++) begin
                    gp = gp & p[m];
                end
                t = t | gp;
            end
            c[i+1] = t;
        end
    end

    assign s     = p ^ c[SEG-1:0];
    assign co    = c[SEG];
    assign c_msb = c[SEG-1];

endmodule

// File: rtl/cla_pipe_adder.sv
// Pipelined add/sub: one SEG-bit lookahead slice per stage, valid/ready flow.
// Define CLA_PIPE_SAT_EN to add the sat input and saturating results.
module cla_pipe_adder
    import cla_pkg::*;
#(
    parameter int WIDTH = CLA_WIDTH_DEF,
    parameter int SEG   = CLA_SEG_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
`ifdef CLA_PIPE_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int STAGES = WIDTH / SEG;

    if (!cla_cfg_ok(WIDTH, SEG)) begin : g_cfg_err
        $error("cla_pipe_adder: illegal WIDTH/SEG combination");
    end

`ifdef CLA_PIPE_SAT_EN
    localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic [WIDTH-1:0] SAT_MIN = ~SAT_MAX;
`endif

    logic       adv;
    logic       sat_w;
    cla_stage_t head;

`ifdef CLA_PIPE_SAT_EN
    assign sat_w = sat;
`else
    assign sat_w = 1'b0;
`endif

    // Whole pipe moves together whenever the output slot can be vacated
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    // Build the entering record; sub forces carry-in 1 and ignores cin
    always_comb begin
        head                = '0;
        head.valid          = in_valid;
        head.a[WIDTH-1:0]   = a;
        head.b[WIDTH-1:0]   = b;
        head.sub            = sub;
        head.sat            = sat_w;
        head.carry          = sub | cin;
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        cla_stage_t     prv;
        cla_stage_t     st_d;
        cla_stage_t     st_q;
        logic [SEG-1:0] seg_a;
        logic [SEG-1:0] seg_b;
        logic [SEG-1:0] seg_s;
        logic           seg_co;
        logic           seg_cm;

        if (k == 0) begin : g_head
            assign prv = head;
        end else begin : g_link
            assign prv = g_st[k-1].st_q;
        end

        assign seg_a = prv.a[k*SEG +: SEG];
        assign seg_b = prv.b[k*SEG +: SEG] ^ {SEG{prv.sub}};

        cla_seg #(
            .SEG   (SEG)
        ) u_seg (
            .a     (seg_a),
            .b     (seg_b),
            .ci    (prv.carry),
            .s     (seg_s),
            .co    (seg_co),
            .c_msb (seg_cm)
        );

        // Resolve this slice and hand its carry to the next stage
        always_comb begin
            st_d                     = prv;
            st_d.psum[k*SEG +: SEG]  = seg_s;
            st_d.carry               = seg_co;
            st_d.ovf                 = seg_co ^ seg_cm;
`ifdef CLA_PIPE_SAT_EN
            // Sign of a picks the rail: a >= 0 can only overflow upward
            if ((k == STAGES - 1) && prv.sat && (seg_co ^ seg_cm)) begin
                st_d.psum[WIDTH-1:0] = prv.a[WIDTH-1] ? SAT_MIN : SAT_MAX;
            end
`endif
        end

        // Stage register: cleared on reset, frozen while output stalls
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                st_q <= '0;
            end else if (adv) begin
                st_q <= st_d;
            end
        end
    end

    assign out_valid = g_st[STAGES-1].st_q.valid;
    assign sum       = g_st[STAGES-1].st_q.psum[WIDTH-1:0];
    assign cout      = g_st[STAGES-1].st_q.carry;
    assign ovf       = g_st[STAGES-1].st_q.ovf;

endmodule

// File: tb/tb_cla_pipe_adder.sv
// Self-checking bench for cla_pipe_adder (32/8 main, 16/4 and 8/8 corners).
// Scoreboard expectations come from plain two's-complement arithmetic.
module tb_cla_pipe_adder;

`ifdef CLA_PIPE_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        cin;
    logic        sub;
    logic        sat;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] sum;
    logic        cout;
    logic        ovf;

    logic        v16, r16, ov16, or16, co16, of16, ci16, sb16;
    logic [15:0] a16, b16, s16;
    logic        v8, r8, ov8, or8, co8, of8, ci8, sb8;
    logic [7:0]  a8, b8, s8;
`ifdef CLA_PIPE_SAT_EN
    logic        sat16, sat8;
`endif

    int n_chk = 0;
    int n_err = 0;
    int n_out = 0;
    logic [31:0] last_sum;
    logic        last_co;
    logic        last_ov;
    logic [33:0] exp_q[$];

    cla_pipe_adder #(.WIDTH(32), .SEG(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
`ifdef CLA_PIPE_SAT_EN
        .sat       (sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sum       (sum),
        .cout      (cout),
        .ovf       (ovf)
    );

    cla_pipe_adder #(.WIDTH(16), .SEG(4)) dut16 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v16),
        .in_ready  (r16),
        .a         (a16),
        .b         (b16),
        .cin       (ci16),
        .sub       (sb16),
`ifdef CLA_PIPE_SAT_EN
        .sat       (sat16),
`endif
        .out_valid (ov16),
        .out_ready (or16),
        .sum       (s16),
        .cout      (co16),
        .ovf       (of16)
    );

    cla_pipe_adder #(.WIDTH(8), .SEG(8)) dut8 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (v8),
        .in_ready  (r8),
        .a         (a8),
        .b         (b8),
        .cin       (ci8),
        .sub       (sb8),
`ifdef CLA_PIPE_SAT_EN
        .sat       (sat8),
`endif
        .out_valid (ov8),
        .out_ready (or8),
        .sum       (s8),
        .cout      (co8),
        .ovf       (of8)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // Reference: {ovf, cout, sum} from ordinary wide arithmetic
    function automatic logic [33:0] model(input logic [31:0] x,
                                          input logic [31:0] y,
                                          input logic ci, input logic s,
                                          input logic st);
        logic [63:0] full;
        logic [31:0] r;
        logic        ov;
        if (s) begin
            full = {32'd0, x} + {32'd0, ~y} + 64'd1;
            r    = full[31:0];
            ov   = (x[31] != y[31]) && (r[31] != x[31]);
        end else begin
            full = {32'd0, x} + {32'd0, y} + {63'd0, ci};
            r    = full[31:0];
            ov   = (x[31] == y[31]) && (r[31] != x[31]);
        end
        if (SAT_EN && st && ov) begin
            r = x[31] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        end
        return {ov, full[32], r};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock of the main DUT, entered and left at a falling edge
    task automatic step(input logic iv, input logic [31:0] ia,
                        input logic [31:0] ib, input logic ic,
                        input logic is, input logic ist,
                        input logic ordy, output logic acc);
        logic [33:0] e;
        in_valid  = iv;
        a         = ia;
        b         = ib;
        cin       = ic;
        sub       = is;
        sat       = ist;
        out_ready = ordy;
        #1;
        acc = in_valid && in_ready;
        if (out_valid && out_ready) begin
            n_out++;
            last_sum = sum;
            last_co  = cout;
            last_ov  = ovf;
            if (exp_q.size() == 0) begin
                chk("unexpected_output", 64'd0, 64'd1);
            end else begin
                e = exp_q.pop_front();
                chk("sum", sum, e[31:0]);
                chk("cout", cout, e[32]);
                chk("ovf", ovf, e[33]);
            end
        end
        if (acc) exp_q.push_back(model(ia, ib, ic, is, ist));
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic lat_probe(output int k);
        int   n0;
        logic acc;
        k  = 0;
        n0 = n_out;
        while (n_out == n0 && k < 12) begin
            k++;
            step(1'b0, 32'd0, 32'd0, 1'b0, 1'b0, 1'b0, 1'b1, acc);
        end
    endtask

    initial begin
        logic        acc;
        int          k;
        int          n0;
        int          i;
        logic        iv;
        logic [31:0] ra;
        logic [31:0] rb;

        rst_n = 1'b0;
        in_valid = 0; a = 0; b = 0; cin = 0; sub = 0; sat = 0;
        out_ready = 1'b0;
        v16 = 0; a16 = 0; b16 = 0; ci16 = 0; sb16 = 0; or16 = 1;
        v8 = 0; a8 = 0; b8 = 0; ci8 = 0; sb8 = 0; or8 = 1;
`ifdef CLA_PIPE_SAT_EN
        sat16 = 0; sat8 = 0;
`endif

        // Reset state
        repeat (2) @(negedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", cout, 0);
        chk("rst_ovf", ovf, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("in_ready_after_rst", in_ready, 1);
        @(negedge clk);

        // Carry through all 32 bits
        step(1, 32'hFFFF_FFFF, 32'h1, 0, 0, 0, 1, acc);
        chk("acc_add", acc, 1);
        lat_probe(k);
        chk("lat_add", k, 4);
        chk("add_sum", last_sum, 32'h0);
        chk("add_cout", last_co, 1);
        chk("add_ovf", last_ov, 0);

        // Subtract with signed overflow; cin must be ignored
        step(1, 32'h8000_0000, 32'h1, 1, 1, 0, 1, acc);
        lat_probe(k);
        chk("lat_sub", k, 4);
        chk("sub_sum", last_sum, 32'h7FFF_FFFF);
        chk("sub_cout", last_co, 1);
        chk("sub_ovf", last_ov, 1);
`ifdef CLA_PIPE_SAT_EN
        step(1, 32'h8000_0000, 32'h1, 0, 1, 1, 1, acc);
        lat_probe(k);
        chk("sat_sum", last_sum, 32'h8000_0000);
        chk("sat_ovf", last_ov, 1);
        step(1, 32'h7FFF_FFFF, 32'h1, 0, 0, 1, 1, acc);
        lat_probe(k);
        chk("sat_pos_sum", last_sum, 32'h7FFF_FFFF);
`endif

        // Back-to-back i+i with the output stalled on cycles 5..7
        i  = 1;
        n0 = n_out;
        for (int c = 1; c <= 40; c++) begin
            iv = (i <= 8);
            step(iv, i, i, 0, 0, 0, !(c >= 5 && c <= 7), acc);
            if (c >= 5 && c <= 7) chk("b2b_stall_ready", acc, 0);
            else if (c <= 4) chk("b2b_run_ready", acc, 1);
            if (acc) i++;
            if (i > 8 && exp_q.size() == 0) break;
        end
        chk("b2b_count", n_out - n0, 8);
        chk("b2b_sb_empty", exp_q.size(), 0);

        // Random traffic with random bubbles and back-pressure
        for (int t = 0; t < 400; t++) begin
            ra = $urandom;
            rb = $urandom;
            if ($urandom_range(0, 7) == 0) ra = 32'h7FFF_FFFF;
            if ($urandom_range(0, 7) == 0) rb = 32'h8000_0000;
            step($urandom_range(0, 3) != 0, ra, rb,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, acc);
        end
        for (int t = 0; t < 30 && exp_q.size() != 0; t++) begin
            step(0, 0, 0, 0, 0, 0, 1, acc);
        end
        chk("rand_drain_empty", exp_q.size(), 0);

        // Reset mid-flight discards everything in the pipe
        for (int t = 1; t <= 4; t++) begin
            step(1, t * 32'h1111_1111, 32'h3, 0, 0, 0, 1, acc);
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("pre_rst_valid", out_valid, 1);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_sum", sum, 0);
        exp_q.delete();
        @(posedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        #1;
        chk("midrst_in_ready", in_ready, 1);
        @(negedge clk);
        n0 = n_out;
        repeat (8) step(0, 0, 0, 0, 0, 0, 1, acc);
        chk("midrst_no_ghost", n_out - n0, 0);
        step(1, 32'h1234_5678, 32'h1111_1111, 1, 0, 0, 1, acc);
        lat_probe(k);
        chk("midrst_new_lat", k, 4);
        chk("midrst_new_sum", last_sum, 32'h2345_678A);

        // 16-bit, 4-bit segments: four stages
        a16 = 16'h7FFF; b16 = 16'h0001; v16 = 1;
        @(posedge clk);
        #1;
        v16 = 0;
        k = 0;
        while (!ov16 && k < 12) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("w16_lat", k + 1, 4);
        chk("w16_sum", s16, 16'h8000);
        chk("w16_ovf", of16, 1);
        chk("w16_cout", co16, 0);

        // Single-stage degenerate case
        a8 = 8'hFF; b8 = 8'h01; v8 = 1;
        @(posedge clk);
        #1;
        v8 = 0;
        k = 0;
        while (!ov8 && k < 12) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("w8_lat", k + 1, 1);
        chk("w8_sum", s8, 8'h00);
        chk("w8_cout", co8, 1);
        chk("w8_ovf", of8, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
